// File: rtl/video_rx_checker.sv
// Receive-side checker: recovers line/frame structure from BLANK/VS and measures it.
// Optional per-frame RGB checksum enabled by VIDEO_RX_CHECKSUM_EN.
module video_rx_checker #(
  parameter int HDISP = 800,
  parameter int VDISP = 480
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic        HS,
  input  logic        VS,
  input  logic        BLANK,
  input  logic [23:0] RGB,
  input  logic        err_clr,
  output logic        frame_done,
  output logic [11:0] h_meas,
  output logic [10:0] v_meas,
  output logic        h_err,
  output logic        v_err,
  output logic [31:0] checksum,
  output logic [15:0] frame_count
);

  typedef enum logic {SYNC, RUN} state_t;

  state_t state, state_nxt;

  logic        unused_hs_q;
  logic        vs_q, vs_qq;
  logic        blank_q, blank_qq;
  logic        vs_fall, blank_fall;
  logic        run, line_end, frame_end;
  logic        h_set, v_set;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt, v_line;

  // Sync/blank idle values chosen so reset never fakes an edge.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      unused_hs_q <= 1'b1;
      vs_q        <= 1'b1;
      vs_qq       <= 1'b1;
      blank_q     <= 1'b0;
      blank_qq    <= 1'b0;
    end else begin
      unused_hs_q <= HS;
      vs_q        <= VS;
      vs_qq       <= vs_q;
      blank_q     <= BLANK;
      blank_qq    <= blank_q;
    end
  end

  assign vs_fall    = vs_qq & ~vs_q;
  assign blank_fall = blank_qq & ~blank_q;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) state <= SYNC;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC:    if (vs_fall) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    run = 1'b0;
    unique case (state)
      RUN:     run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  assign line_end  = run & blank_fall;
  assign frame_end = run & vs_fall;

  // A line closing on the frame edge still counts toward v_meas.
  always_comb begin
    v_line = v_cnt;
    if (line_end && v_cnt != 11'h7ff) v_line = v_cnt + 11'd1;
  end

  assign h_set = line_end & (h_cnt != 12'(HDISP));
  assign v_set = frame_end & (v_line != 11'(VDISP));

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (!run || line_end || frame_end) h_cnt <= '0;
      else if (blank_q && h_cnt != 12'hfff) h_cnt <= h_cnt + 12'd1;
      if (!run || frame_end) v_cnt <= '0;
      else                   v_cnt <= v_line;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      frame_done  <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= frame_end;
      if (line_end) h_meas <= h_cnt;
      if (frame_end) begin
        v_meas      <= v_line;
        frame_count <= frame_count + 16'd1;
      end
      h_err <= h_set | (h_err & ~err_clr);
      v_err <= v_set | (v_err & ~err_clr);
    end
  end

`ifdef VIDEO_RX_CHECKSUM_EN
  logic [23:0] rgb_q;
  logic [31:0] sum_acc;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      rgb_q    <= '0;
      sum_acc  <= '0;
      checksum <= '0;
    end else begin
      rgb_q <= RGB;
      if (!run || frame_end) sum_acc <= '0;
      else if (blank_q)      sum_acc <= sum_acc + {8'h0, rgb_q};
      if (frame_end) checksum <= sum_acc;
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^RGB;
  assign checksum   = 32'h0;
`endif

endmodule

// File: tb/tb_video_rx_checker.sv
// Directed bench for video_rx_checker at HDISP=160, VDISP=90.
// Expected checksum depends on whether VIDEO_RX_CHECKSUM_EN is defined.
module tb_video_rx_checker;

  localparam int HD = 160;
  localparam int VD = 90;
`ifdef VIDEO_RX_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs, vs, blank, err_clr;
  logic [23:0] rgb;
  logic        frame_done, h_err, v_err;
  logic [11:0] h_meas;
  logic [10:0] v_meas;
  logic [31:0] checksum;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic fd, fd_extra;

  always #10 clk = ~clk;

  video_rx_checker #(.HDISP(HD), .VDISP(VD)) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n),
    .HS(hs), .VS(vs), .BLANK(blank), .RGB(rgb),
    .err_clr(err_clr), .frame_done(frame_done),
    .h_meas(h_meas), .v_meas(v_meas),
    .h_err(h_err), .v_err(v_err),
    .checksum(checksum), .frame_count(frame_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int n, input logic [23:0] c);
    for (int i = 0; i < n; i++) begin
      blank = 1'b1;
      rgb   = c;
      @(negedge clk);
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      blank = 1'b0;
      rgb   = 24'h0;
      hs    = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    hs = 1'b1;
  endtask

  task automatic line(input int n, input logic [23:0] c);
    pix(n, c);
    gap(4);
  endtask

  task automatic vsync(output logic done, output logic extra);
    vs    = 1'b0;
    blank = 1'b0;
    @(negedge clk);
    extra = frame_done;
    @(negedge clk);
    done = frame_done;
    @(negedge clk);
    extra = extra | frame_done;
    vs = 1'b1;
    gap(3);
  endtask

  initial begin
    rst_n = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0;
    rgb = 24'h0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", frame_done, 0);
    chk("rst_hmeas", h_meas, 0);
    chk("rst_vmeas", v_meas, 0);
    chk("rst_errs", {h_err, v_err}, 0);
    chk("rst_cksum", checksum, 0);
    chk("rst_fcnt", frame_count, 0);
    rst_n = 1'b1;

    line(50, 24'h000001);
    chk("sync_hmeas", h_meas, 0);
    vsync(fd, fd_extra);
    chk("sync_nodone", {fd, fd_extra}, 0);
    chk("sync_fcnt", frame_count, 0);

    for (int i = 0; i < VD; i++) line(HD, 24'h000001);
    vsync(fd, fd_extra);
    chk("nom_done", fd, 1);
    chk("nom_pulse1", fd_extra, 0);
    chk("nom_fcnt", frame_count, 1);
    chk("nom_hmeas", h_meas, 160);
    chk("nom_vmeas", v_meas, 90);
    chk("nom_cksum", checksum, CS ? 32'h3840 : 32'h0);
    chk("nom_errs", {h_err, v_err}, 0);

    for (int i = 0; i < VD - 1; i++) begin
      if (i == 9) begin
        pix(HD - 1, 24'h000001);
        gap(1);
        chk("short_herr_early", h_err, 0);
        gap(1);
        chk("short_herr_2cyc", h_err, 1);
        chk("short_hmeas", h_meas, 159);
        gap(2);
      end else begin
        line(HD, 24'h000001);
      end
    end
    vsync(fd, fd_extra);
    chk("sf_done", fd, 1);
    chk("sf_vmeas", v_meas, 89);
    chk("sf_verr", v_err, 1);
    chk("sf_herr", h_err, 1);
    chk("sf_cksum", checksum, CS ? 32'h379f : 32'h0);

    for (int i = 0; i < VD; i++) line(HD, 24'hffffff);
    vsync(fd, fd_extra);
    chk("good_vmeas", v_meas, 90);
    chk("good_hmeas", h_meas, 160);
    chk("good_sticky", {h_err, v_err}, 2'b11);
    chk("good_cksum", checksum, CS ? 32'h3fffc7c0 : 32'h0);
    chk("good_fcnt", frame_count, 3);

    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_errs", {h_err, v_err}, 0);

    pix(HD + 1, 24'h000001);
    blank = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("coll_herr", h_err, 1);
    chk("coll_hmeas", h_meas, 161);
    gap(3);
    chk("coll_herr_hold", h_err, 1);
    pix(HD, 24'h000001);
    vsync(fd, fd_extra);
    chk("same_vmeas", v_meas, 2);
    chk("same_hmeas", h_meas, 160);
    chk("same_verr", v_err, 1);
    chk("same_fcnt", frame_count, 4);

    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vsync(fd, fd_extra);
    chk("zero_done", fd, 1);
    chk("zero_vmeas", v_meas, 0);
    chk("zero_verr", v_err, 1);
    chk("zero_herr", h_err, 0);

    pix(30, 24'h000001);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_fcnt", frame_count, 0);
    chk("mid_errs", {h_err, v_err}, 0);
    chk("mid_hmeas", h_meas, 0);
    rst_n = 1'b1;
    gap(4);
    vsync(fd, fd_extra);
    chk("mid_sync_nodone", {fd, fd_extra}, 0);
    vsync(fd, fd_extra);
    chk("mid_run_done", fd, 1);
    chk("mid_run_fcnt", frame_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
